mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//   MEM-stage load/store unit of the RV32I core. Accepts one load/store per cycle from EX/MEM,
//   drives the synchronous data RAM and the LED/tohost MMIO registers, and returns formatted load data.
//   Generates byte-lane enables and sign/zero extension from funct3_mem_t.
//   Halts on a tohost write.
//   Uses XLEN, ALEN, RAM_MEMORY_SIZE, LED_WIDTH, MMIO_LED_ADDR and MMIO_TOHOST_ADDR from riscv_pkg.
// PARAMETERS
//   RAM_WORDS  RAM_MEMORY_SIZE  data RAM depth in 32-bit words; index width = $clog2(RAM_WORDS)
//   LED_W      LED_WIDTH        width of the LED output register
// PORTS
//   clk           in   1          core clock, all state on rising edge
//   rst_n         in   1          asynchronous active-low reset
//   req_valid     in   1          access request present
//   req_ready     out  1          unit can accept; transfer = req_valid & req_ready
//   req_we        in   1          1 = store, 0 = load
//   req_funct3    in   3          funct3_mem_t: BYTE/HALF/WORD/LBU/LHU
//   req_addr      in   ALEN       byte address
//   req_wdata     in   XLEN       store data, right-aligned
//   rsp_valid     out  1          response for the access accepted on the previous cycle
//   rsp_rdata     out  XLEN       extended load data; 0 for stores and errors
//   rsp_err       out  1          misaligned, illegal funct3 or unmapped address; qualified by rsp_valid
//   ram_en        out  1          RAM access strobe; read data returns next cycle
//   ram_we        out  4          byte write enables
//   ram_addr      out  $clog2(RAM_WORDS)  word index = req_addr[..:2]
//   ram_wdata     out  XLEN       lane-replicated store data
//   ram_rdata     in   XLEN       RAM read word, valid the cycle after ram_en
//   led_o         out  LED_W      LED register
//   tohost_o      out  XLEN       last value written to tohost
//   halted_o      out  1          set by a tohost store; sticky until reset
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, req_ready=0 while rst_n=0; all other outputs 0; led_o=0; tohost_o=0; halted_o=0.
//   FSM states:
//   - IDLE: req_ready=1, rsp_valid=0. On accept -> RESP.
//   - RESP: rsp_valid=1, req_ready=1. On accept stay RESP, else -> IDLE.
//     Throughput 1/cycle, latency 1 cycle.
//   - HALT: req_ready=0, rsp_valid=0, no RAM/MMIO activity. Left only by reset.
//     Entered from IDLE/RESP on acceptance of a good tohost store. That store's response is issued in the
//     next cycle, then state=HALT; halted_o=1 from the cycle after the accept.
//   Decode at accept (combinational on request):
//   - RAM hit: addr < RAM_WORDS*4. MMIO hit: addr == MMIO_LED_ADDR or MMIO_TOHOST_ADDR. Else unmapped -> err.
//   - Misaligned: HALF/LHU with addr[0]=1, or WORD with addr[1:0]!=0 -> err.
//   - funct3 011/110/111 -> err; stores with LBU/LHU -> err.
//   - MMIO accesses must be WORD, else err.
//   - Error access has no side effect: ram_en=0, no MMIO write.
//   RAM store: ram_en=1.
//   - ram_we = SB: 1<<addr[1:0]; SH: addr[1] ? 1100 : 0011; SW: 1111.
//   - ram_wdata = SB: {4{wdata[7:0]}}; SH: {2{wdata[15:0]}}; SW: wdata.
//   RAM load: ram_en=1, ram_we=0. Offset and funct3 are registered. In RESP, select the lane from ram_rdata
//   by the registered offset; sign-extend BYTE/HALF, zero-extend LBU/LHU.
//   MMIO store: the LED register takes wdata[LED_W-1:0] at the accept edge; tohost_o takes wdata.
//   MMIO load: read data is registered at accept. LED read returns zero-extended led_o; tohost read returns tohost_o.
//   rsp_rdata and rsp_err are 0 whenever rsp_valid=0.
//   Reset mid-RESP drops the pending response. Writes already committed to RAM/MMIO stand.
// TESTING
//   - SW 0xDEADBEEF @0x100, then LW @0x100 back-to-back -> ram_we=1111; next cycle rsp_valid=1, rsp_rdata=0xDEADBEEF, req_ready stays 1.
//   - SB 0x80 @0x103, LB @0x103, LBU @0x103 -> ram_we=1000, ram_wdata=0x80808080; rsp_rdata=0xFFFFFF80 then 0x00000080.
//   - LH @0x101 and SW @0x102 -> rsp_err=1, ram_en=0, RAM contents unchanged.
//   - SW 0x5 @MMIO_LED_ADDR, then LW same addr -> led_o=0x5 one cycle after accept; rsp_rdata=0x00000005.
//   - SW 0x1 @MMIO_TOHOST_ADDR -> tohost_o=1, halted_o=1, req_ready=0 forever; a following req_valid is never accepted.
//   - Assert rst_n=0 while in RESP -> rsp_valid=0, led_o=0, halted_o=0 immediately (async); state IDLE after release.

Source files
------------

// File: rtl/mem_access_unit.sv
// riscv_pkg: core-wide widths, memory map and the load/store funct3 encoding.
// mem_access_unit: MEM-stage load/store unit driving the data RAM and the LED/tohost MMIO registers.
package riscv_pkg;
   localparam int XLEN            = 32;
   localparam int ALEN            = 32;
   localparam int RAM_MEMORY_SIZE = 1024;
   localparam int LED_WIDTH       = 8;
   localparam logic [ALEN-1:0] MMIO_LED_ADDR    = 32'h8000_0000;
   localparam logic [ALEN-1:0] MMIO_TOHOST_ADDR = 32'h8000_0010;

   typedef enum logic [2:0] {
      F3_BYTE = 3'b000,
      F3_HALF = 3'b001,
      F3_WORD = 3'b010,
      F3_LBU  = 3'b100,
      F3_LHU  = 3'b101
   } funct3_mem_t;
endpackage

module mem_access_unit
   import riscv_pkg::*;
#(
   parameter int RAM_WORDS = RAM_MEMORY_SIZE,
   parameter int LED_W     = LED_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_we,
   input  logic [2:0]                   req_funct3,
   input  logic [ALEN-1:0]              req_addr,
   input  logic [XLEN-1:0]              req_wdata,
   output logic                         rsp_valid,
   output logic [XLEN-1:0]              rsp_rdata,
   output logic                         rsp_err,
   output logic                         ram_en,
   output logic [3:0]                   ram_we,
   output logic [$clog2(RAM_WORDS)-1:0] ram_addr,
   output logic [XLEN-1:0]              ram_wdata,
   input  logic [XLEN-1:0]              ram_rdata,
   output logic [LED_W-1:0]             led_o,
   output logic [XLEN-1:0]              tohost_o,
   output logic                         halted_o
);

   localparam int IDX_W = $clog2(RAM_WORDS);
   localparam logic [ALEN-1:0] RAM_BYTES = ALEN'(RAM_WORDS * 4);

   typedef enum logic [1:0] {
      IDLE,
      RESP,
      RESP_LAST,
      HALT
   } state_t;

   state_t state, state_next;

   logic            accept;
   logic            ram_hit, led_hit, tohost_hit;
   logic            f3_legal, misaligned, req_err, good;
   logic            halt_store;
   logic [LED_W-1:0] led_q;
   logic [XLEN-1:0] tohost_q;
   logic            rsp_err_q, load_ram_q;
   logic [XLEN-1:0] mmio_rdata_q;
   logic [1:0]      off_q;
   logic [2:0]      f3_q;
   logic [7:0]      lane_byte;
   logic [15:0]     lane_half;

   assign req_ready  = rst_n && (state == IDLE || state == RESP);
   assign accept     = req_valid && req_ready;
   assign ram_hit    = req_addr < RAM_BYTES;
   assign led_hit    = req_addr == MMIO_LED_ADDR;
   assign tohost_hit = req_addr == MMIO_TOHOST_ADDR;
   assign req_err    = !f3_legal || misaligned || !(ram_hit || led_hit || tohost_hit)
                       || ((led_hit || tohost_hit) && req_funct3 != F3_WORD);
   assign good       = accept && !req_err;
   assign halt_store = good && req_we && tohost_hit;
   assign halted_o   = (state == RESP_LAST) || (state == HALT);
   assign led_o      = led_q;
   assign tohost_o   = tohost_q;

   // Classify the request's funct3 and alignment; zero-extending loads cannot be stores.
   always_comb begin
      f3_legal   = 1'b0;
      misaligned = 1'b0;
      case (req_funct3)
         F3_BYTE: f3_legal = 1'b1;
         F3_HALF: begin
            f3_legal   = 1'b1;
            misaligned = req_addr[0];
         end
         F3_WORD: begin
            f3_legal   = 1'b1;
            misaligned = |req_addr[1:0];
         end
         F3_LBU: f3_legal = !req_we;
         F3_LHU: begin
            f3_legal   = !req_we;
            misaligned = req_addr[0];
         end
         default: f3_legal = 1'b0;
      endcase
   end

   // Drive the RAM port for a good RAM access, replicating store data across the lanes.
   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 4'b0000;
      ram_addr  = '0;
      ram_wdata = '0;
      if (good && ram_hit) begin
         ram_en   = 1'b1;
         ram_addr = req_addr[IDX_W+1:2];
         if (req_we) begin
            case (req_funct3)
               F3_BYTE: begin
                  ram_we    = 4'b0001 << req_addr[1:0];
                  ram_wdata = {4{req_wdata[7:0]}};
               end
               F3_HALF: begin
                  ram_we    = req_addr[1] ? 4'b1100 : 4'b0011;
                  ram_wdata = {2{req_wdata[15:0]}};
               end
               default: begin
                  ram_we    = 4'b1111;
                  ram_wdata = req_wdata;
               end
            endcase
         end
      end
   end

   // Next state and response-valid; a tohost store gets its response in RESP_LAST before HALT.
   always_comb begin
      state_next = state;
      rsp_valid  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_next = halt_store ? RESP_LAST : RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (accept) state_next = halt_store ? RESP_LAST : RESP;
            else        state_next = IDLE;
         end
         RESP_LAST: begin
            rsp_valid  = 1'b1;
            state_next = HALT;
         end
         default: state_next = HALT;
      endcase
   end

   // State register plus MMIO registers and the per-access response context captured at accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         led_q        <= '0;
         tohost_q     <= '0;
         rsp_err_q    <= 1'b0;
         load_ram_q   <= 1'b0;
         mmio_rdata_q <= '0;
         off_q        <= 2'b00;
         f3_q         <= 3'b000;
      end else begin
         state <= state_next;
         if (good && req_we && led_hit)    led_q    <= req_wdata[LED_W-1:0];
         if (good && req_we && tohost_hit) tohost_q <= req_wdata;
         if (accept) begin
            rsp_err_q  <= req_err;
            load_ram_q <= good && ram_hit && !req_we;
            off_q      <= req_addr[1:0];
            f3_q       <= req_funct3;
            if (good && !req_we && led_hit)         mmio_rdata_q <= XLEN'(led_q);
            else if (good && !req_we && tohost_hit) mmio_rdata_q <= tohost_q;
            else                                    mmio_rdata_q <= '0;
         end
      end
   end

   // Format the response: pick the lane of the RAM word and extend, or return the MMIO value.
   always_comb begin
      rsp_rdata = '0;
      rsp_err   = 1'b0;
      case (off_q)
         2'd0:    lane_byte = ram_rdata[7:0];
         2'd1:    lane_byte = ram_rdata[15:8];
         2'd2:    lane_byte = ram_rdata[23:16];
         default: lane_byte = ram_rdata[31:24];
      endcase
      lane_half = off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
      if (rsp_valid) begin
         rsp_err = rsp_err_q;
         if (load_ram_q) begin
            case (f3_q)
               F3_BYTE: rsp_rdata = {{24{lane_byte[7]}}, lane_byte};
               F3_HALF: rsp_rdata = {{16{lane_half[15]}}, lane_half};
               F3_LBU:  rsp_rdata = {24'h0, lane_byte};
               F3_LHU:  rsp_rdata = {16'h0, lane_half};
               default: rsp_rdata = ram_rdata;
            endcase
         end else begin
            rsp_rdata = mmio_rdata_q;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, random traffic against a byte-level model,
// plus hand-written reset-during-response and tohost-halt sequences.
module tb_mem_access_unit;
   import riscv_pkg::*;

   localparam int RAM_WORDS = 1024;
   localparam int LED_W     = 8;
   localparam int RAM_BYTES = RAM_WORDS * 4;
   localparam logic [31:0] LED_A = 32'h8000_0000;
   localparam logic [31:0] TOH_A = 32'h8000_0010;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        ram_en;
   logic [3:0]  ram_we;
   logic [9:0]  ram_addr;
   logic [31:0] ram_wdata, ram_rdata;
   logic [LED_W-1:0] led_o;
   logic [31:0] tohost_o;
   logic        halted_o;

   int n_tests = 0;
   int n_fail  = 0;

   mem_access_unit #(.RAM_WORDS(RAM_WORDS), .LED_W(LED_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .led_o(led_o), .tohost_o(tohost_o), .halted_o(halted_o)
   );

   always #5 clk = ~clk;

   // Synchronous byte-enable RAM attached to the unit.
   logic [31:0] ram_mem [0:RAM_WORDS-1];
   always @(posedge clk) begin
      if (ram_en) begin
         for (int k = 0; k < 4; k++)
            if (ram_we[k]) ram_mem[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
         if (ram_we == 4'b0000) ram_rdata <= ram_mem[ram_addr];
      end
   end

   // Reference model: byte-addressed memory and MMIO state.
   logic [7:0]  m_mem [0:RAM_BYTES-1];
   logic [7:0]  m_led;
   logic [31:0] m_tohost;
   bit          m_halted;
   bit          exp_rsp_valid;
   bit          exp_rsp_err;
   logic [31:0] exp_rsp_rdata;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [19];

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void decode(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                  output bit err, output int size, output bit is_ram,
                                  output bit is_led, output bit is_toh);
      bit legal;
      size   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      legal  = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5) && !(we && f3[2]);
      is_ram = a < RAM_BYTES;
      is_led = a == LED_A;
      is_toh = a == TOH_A;
      err    = !legal || (a % size != 0) || !(is_ram || is_led || is_toh)
               || ((is_led || is_toh) && f3 != 3'd2);
   endfunction

   // Drive one request, check the previous response and this cycle's RAM port, then advance the model.
   task automatic apply_stimulus(input logic v, input logic we, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd);
      bit err, is_ram, is_led, is_toh, acc, exp_en;
      int size;
      logic [3:0]  mask;
      logic [31:0] rep, val;
      req_valid = v; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      #2;
      check_output("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
      check_output("rsp_err", 32'(rsp_err), 32'(exp_rsp_err));
      check_output("rsp_rdata", rsp_rdata, exp_rsp_rdata);
      decode(we, f3, a, err, size, is_ram, is_led, is_toh);
      acc    = v && !m_halted;
      exp_en = acc && !err && is_ram;
      mask   = 4'(((1 << size) - 1) << (a % 4));
      rep    = (size == 1) ? {4{wd[7:0]}} : (size == 2) ? {2{wd[15:0]}} : wd;
      check_output("req_ready", 32'(req_ready), 32'(!m_halted));
      check_output("ram_en", 32'(ram_en), 32'(exp_en));
      check_output("ram_we", 32'(ram_we), (exp_en && we) ? 32'(mask) : 32'h0);
      if (exp_en) check_output("ram_addr", 32'(ram_addr), a / 4);
      if (exp_en && we) check_output("ram_wdata", ram_wdata, rep);
      @(posedge clk);
      #1;
      val = 32'h0;
      if (acc && !err) begin
         if (is_ram && !we) begin
            for (int k = 0; k < size; k++) val = val | (32'(m_mem[a + k]) << (8 * k));
            if (!f3[2] && size == 1) val = {{24{val[7]}}, val[7:0]};
            if (!f3[2] && size == 2) val = {{16{val[15]}}, val[15:0]};
         end else if (is_ram) begin
            for (int k = 0; k < size; k++) m_mem[a + k] = 8'(wd >> (8 * k));
         end else if (is_led && !we) val = 32'(m_led);
         else if (is_toh && !we)     val = m_tohost;
         else if (is_led)            m_led = wd[7:0];
         else begin
            m_tohost = wd;
            m_halted = 1'b1;
         end
      end
      exp_rsp_valid = acc;
      exp_rsp_err   = acc && err;
      exp_rsp_rdata = acc ? val : 32'h0;
      check_output("led_o", 32'(led_o), 32'(m_led));
      check_output("tohost_o", tohost_o, m_tohost);
      check_output("halted_o", 32'(halted_o), 32'(m_halted));
   endtask

   initial begin
      vecs[0]  = '{1'b1, 3'd2, 32'h100,  32'hDEADBEEF, 1'b0, 32'h0};
      vecs[1]  = '{1'b0, 3'd2, 32'h100,  32'h0,        1'b0, 32'hDEADBEEF};
      vecs[2]  = '{1'b1, 3'd0, 32'h103,  32'h80,       1'b0, 32'h0};
      vecs[3]  = '{1'b0, 3'd0, 32'h103,  32'h0,        1'b0, 32'hFFFFFF80};
      vecs[4]  = '{1'b0, 3'd4, 32'h103,  32'h0,        1'b0, 32'h00000080};
      vecs[5]  = '{1'b0, 3'd1, 32'h101,  32'h0,        1'b1, 32'h0};
      vecs[6]  = '{1'b1, 3'd2, 32'h102,  32'h12345678, 1'b1, 32'h0};
      vecs[7]  = '{1'b0, 3'd2, 32'h100,  32'h0,        1'b0, 32'h80ADBEEF};
      vecs[8]  = '{1'b1, 3'd1, 32'h102,  32'h0000ABCD, 1'b0, 32'h0};
      vecs[9]  = '{1'b0, 3'd5, 32'h102,  32'h0,        1'b0, 32'h0000ABCD};
      vecs[10] = '{1'b0, 3'd1, 32'h102,  32'h0,        1'b0, 32'hFFFFABCD};
      vecs[11] = '{1'b0, 3'd1, 32'h100,  32'h0,        1'b0, 32'hFFFFBEEF};
      vecs[12] = '{1'b0, 3'd3, 32'h100,  32'h0,        1'b1, 32'h0};
      vecs[13] = '{1'b1, 3'd4, 32'h100,  32'h11,       1'b1, 32'h0};
      vecs[14] = '{1'b0, 3'd2, 32'h1000, 32'h0,        1'b1, 32'h0};
      vecs[15] = '{1'b1, 3'd2, LED_A,    32'h5,        1'b0, 32'h0};
      vecs[16] = '{1'b0, 3'd2, LED_A,    32'h0,        1'b0, 32'h5};
      vecs[17] = '{1'b0, 3'd0, LED_A,    32'h0,        1'b1, 32'h0};
      vecs[18] = '{1'b0, 3'd2, TOH_A,    32'h0,        1'b0, 32'h0};

      for (int i = 0; i < RAM_WORDS; i++) ram_mem[i] = 32'h0;
      for (int i = 0; i < RAM_BYTES; i++) m_mem[i] = 8'h00;
      ram_rdata = 32'h0;
      m_led = 8'h00; m_tohost = 32'h0; m_halted = 1'b0;
      exp_rsp_valid = 1'b0; exp_rsp_err = 1'b0; exp_rsp_rdata = 32'h0;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;

      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      req_valid = 1'b1;
      #2;
      check_output("reset req_ready", 32'(req_ready), 32'h0);
      check_output("reset rsp_valid", 32'(rsp_valid), 32'h0);
      check_output("reset ram_en", 32'(ram_en), 32'h0);
      check_output("reset led_o", 32'(led_o), 32'h0);
      check_output("reset tohost_o", tohost_o, 32'h0);
      check_output("reset halted_o", 32'(halted_o), 32'h0);
      req_valid = 1'b0;
      #9 rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 19; i++) begin
         apply_stimulus(1'b1, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
         check_output($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid), 32'h1);
         check_output($sformatf("vec%0d rsp_err", i), 32'(rsp_err), 32'(vecs[i].exp_err));
         check_output($sformatf("vec%0d rsp_rdata", i), rsp_rdata, vecs[i].exp_rdata);
      end
      apply_stimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);

      for (int i = 0; i < 400; i++) begin
         int pick;
         logic [31:0] a;
         logic we;
         pick = $urandom_range(0, 9);
         if (pick <= 6)      a = 32'h200 + 32'($urandom_range(0, 63));
         else if (pick == 7) a = LED_A;
         else if (pick == 8) a = TOH_A;
         else                a = 32'h1000 + 32'($urandom_range(0, 4095));
         we = 1'($urandom_range(0, 1));
         if (a == TOH_A) we = 1'b0;
         apply_stimulus($urandom_range(0, 3) != 0, we, 3'($urandom_range(0, 7)), a, $urandom);
      end

      apply_stimulus(1'b1, 1'b1, 3'd2, LED_A, 32'h7);
      rst_n = 1'b0;
      #1;
      check_output("midresp rsp_valid", 32'(rsp_valid), 32'h0);
      check_output("midresp led_o", 32'(led_o), 32'h0);
      check_output("midresp halted_o", 32'(halted_o), 32'h0);
      check_output("midresp req_ready", 32'(req_ready), 32'h0);
      req_valid = 1'b0;
      m_led = 8'h00; m_tohost = 32'h0; m_halted = 1'b0;
      exp_rsp_valid = 1'b0; exp_rsp_err = 1'b0; exp_rsp_rdata = 32'h0;
      #5 rst_n = 1'b1;
      @(posedge clk);
      #1;
      apply_stimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      apply_stimulus(1'b1, 1'b0, 3'd2, 32'h100, 32'h0);

      apply_stimulus(1'b1, 1'b1, 3'd2, TOH_A, 32'h1);
      check_output("halt req_ready", 32'(req_ready), 32'h0);
      check_output("halt tohost_o", tohost_o, 32'h1);
      for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b1, 3'd2, LED_A, 32'h33);
      check_output("halt rsp_valid", 32'(rsp_valid), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
